// File: rtl/rip_axi_bram_slave.sv
// AXI4 slave backed by a simple dual-port word RAM. Independent read and write FSMs,
// one burst per direction, INCR/FIXED bursts, SLVERR for out-of-range or unsupported bursts.
module rip_axi_bram_slave #(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int MEM_DEPTH_LOG2 = 14
) (
  input  logic                        clk,
  input  logic                        sys_rst,
  input  logic [AXI_ID_WIDTH-1:0]     AWID,
  input  logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]                  AWLEN,
  input  logic [2:0]                  AWSIZE,
  input  logic [1:0]                  AWBURST,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                        WLAST,
  input  logic                        WVALID,
  output logic                        WREADY,
  output logic [AXI_ID_WIDTH-1:0]     BID,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY,
  input  logic [AXI_ID_WIDTH-1:0]     ARID,
  input  logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]                  ARLEN,
  input  logic [2:0]                  ARSIZE,
  input  logic [1:0]                  ARBURST,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  output logic [AXI_ID_WIDTH-1:0]     RID,
  output logic [AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                  RRESP,
  output logic                        RLAST,
  output logic                        RVALID,
  input  logic                        RREADY
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int LANES = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

  w_state_e                  w_state;
  logic [MEM_DEPTH_LOG2-1:0] w_idx;
  logic [7:0]                w_cnt;
  logic                      w_incr;
  logic                      w_err;
  logic                      w_proto_err;

  r_state_e                  r_state;
  logic [MEM_DEPTH_LOG2-1:0] r_idx;
  logic [7:0]                r_cnt;
  logic                      r_incr;
  logic                      r_err;

  logic aw_err, ar_err, w_final, wlast_bad, mem_we;
  logic unused_addr_bits;

  // A burst is rejected for an out-of-range start, a non-word size, or WRAP/reserved type.
  assign aw_err = (AWADDR[AXI_ADDR_WIDTH-1:MEM_DEPTH_LOG2+2] != '0) ||
                  (AWSIZE != 3'b010) || AWBURST[1];
  assign ar_err = (ARADDR[AXI_ADDR_WIDTH-1:MEM_DEPTH_LOG2+2] != '0) ||
                  (ARSIZE != 3'b010) || ARBURST[1];

  assign w_final          = (w_cnt == 8'd0);
  assign wlast_bad        = (WLAST != w_final);
  assign mem_we           = (w_state == W_DATA) && WVALID && !w_err;
  assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < LANES; b++) begin
        if (WSTRB[b]) mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      w_state     <= W_IDLE;
      AWREADY     <= 1'b1;
      WREADY      <= 1'b0;
      BVALID      <= 1'b0;
      BRESP       <= 2'b00;
      BID         <= '0;
      w_idx       <= '0;
      w_cnt       <= 8'd0;
      w_incr      <= 1'b0;
      w_err       <= 1'b0;
      w_proto_err <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (AWVALID) begin
            BID         <= AWID;
            w_idx       <= AWADDR[MEM_DEPTH_LOG2+1:2];
            w_cnt       <= AWLEN;
            w_incr      <= (AWBURST == 2'b01);
            w_err       <= aw_err;
            w_proto_err <= 1'b0;
            AWREADY     <= 1'b0;
            WREADY      <= 1'b1;
            w_state     <= W_DATA;
          end
        end
        // The beat count, not WLAST, ends the burst; a WLAST mismatch only taints BRESP.
        W_DATA: begin
          if (WVALID) begin
            if (w_final) begin
              WREADY  <= 1'b0;
              BVALID  <= 1'b1;
              BRESP   <= (w_err || w_proto_err || wlast_bad) ? 2'b10 : 2'b00;
              w_state <= W_RESP;
            end else begin
              w_cnt <= w_cnt - 8'd1;
              if (w_incr) w_idx <= w_idx + 1'b1;
              if (wlast_bad) w_proto_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      RLAST   <= 1'b0;
      RRESP   <= 2'b00;
      RDATA   <= '0;
      RID     <= '0;
      r_idx   <= '0;
      r_cnt   <= 8'd0;
      r_incr  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID) begin
            RID     <= ARID;
            r_idx   <= ARADDR[MEM_DEPTH_LOG2+1:2];
            r_cnt   <= ARLEN;
            r_incr  <= (ARBURST == 2'b01);
            r_err   <= ar_err;
            ARREADY <= 1'b0;
            r_state <= R_FETCH;
          end
        end
        // RDATA is the registered RAM output; it only changes here, so it holds under back-pressure.
        R_FETCH: begin
          RDATA   <= r_err ? '0 : mem[r_idx];
          RRESP   <= r_err ? 2'b10 : 2'b00;
          RLAST   <= (r_cnt == 8'd0);
          RVALID  <= 1'b1;
          r_state <= R_DATA;
        end
        R_DATA: begin
          if (RREADY) begin
            RVALID <= 1'b0;
            if (RLAST) begin
              RLAST   <= 1'b0;
              ARREADY <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_cnt <= r_cnt - 8'd1;
              if (r_incr) r_idx <= r_idx + 1'b1;
              r_state <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rip_axi_bram_slave.sv
// Self-checking bench for rip_axi_bram_slave: read beats are checked against a scoreboard
// filled from a byte-lane memory model when each read is issued.
module tb_rip_axi_bram_slave;

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  AWID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  always #5 clk = ~clk;

  rip_axi_bram_slave dut (
    .clk(clk), .sys_rst(sys_rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  int          checks = 0;
  int          errors = 0;
  int          lat;
  logic [31:0] wq[$];
  logic [31:0] stall_q[$];
  beat_t       exp_q[$];
  beat_t       obs_q[$];
  logic [31:0] model [int];

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    int idx = int'(addr[15:2]);
    return model.exists(idx) ? model[idx] : 32'h0;
  endfunction

  function automatic void model_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] w = model_rd(addr);
    for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
    model[int'(addr[15:2])] = w;
  endfunction

  // Expected beats are derived from the model at the moment the read is issued.
  function automatic void push_exp(input logic [31:0] addr, input int len, input logic [1:0] burst,
                                   input logic err, input logic [3:0] id);
    logic [31:0] a = addr;
    beat_t b;
    for (int i = 0; i <= len; i++) begin
      b.data = err ? 32'h0 : model_rd(a);
      b.resp = err ? SLVERR : OKAY;
      b.last = (i == len);
      b.id   = id;
      exp_q.push_back(b);
      if (burst == INCR) a = a + 32'd4;
    end
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                          input int bad_last, output logic [1:0] resp, output logic [3:0] bid,
                          output int early_b);
    int t;
    @(posedge clk); #1;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    t = 0;
    while (!AWREADY && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) begin checks++; errors++; $display("[TB] FAIL aw_timeout: AWREADY never 1"); end
    @(posedge clk); #1;
    AWVALID = 1'b0;
    early_b = 0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA  = (wq.size() > 0) ? wq.pop_front() : 32'h0;
      WSTRB  = strb;
      WLAST  = (bad_last < 0) ? (i == int'(len)) : (i == bad_last);
      WVALID = 1'b1;
      t = 0;
      while (!WREADY && t < 100) begin @(posedge clk); #1; t++; end
      if (t >= 100) begin checks++; errors++; $display("[TB] FAIL w_timeout: beat %0d WREADY never 1", i); end
      if (BVALID) early_b++;
      @(posedge clk); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    BREADY = 1'b1;
    t = 0;
    while (!BVALID && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) begin checks++; errors++; $display("[TB] FAIL b_timeout: BVALID never 1"); end
    resp = BRESP; bid = BID;
    @(posedge clk); #1;
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall_beat, input int stall_cycles);
    int t;
    beat_t b;
    @(posedge clk); #1;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    t = 0;
    while (!ARREADY && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) begin checks++; errors++; $display("[TB] FAIL ar_timeout: ARREADY never 1"); end
    @(posedge clk); #1;
    ARVALID = 1'b0;
    lat = 1;
    for (int i = 0; i <= int'(len); i++) begin
      RREADY = (i != stall_beat);
      t = 0;
      while (!RVALID && t < 100) begin @(posedge clk); #1; t++; if (i == 0) lat++; end
      if (t >= 100) begin checks++; errors++; $display("[TB] FAIL r_timeout: beat %0d RVALID never 1", i); end
      if (i == stall_beat) begin
        repeat (stall_cycles) begin @(posedge clk); #1; stall_q.push_back(RDATA); end
        RREADY = 1'b1;
      end
      b.data = RDATA; b.resp = RRESP; b.last = RLAST; b.id = RID;
      obs_q.push_back(b);
      @(posedge clk); #1;
      RREADY = 1'b0;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST} !== 6'b110000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 110000",
               {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST});
    end
    checks++;
    if ({BRESP, RRESP, BID, RID, RDATA} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: BRESP=%b RRESP=%b BID=%h RID=%h RDATA=%h expected all 0",
               BRESP, RRESP, BID, RID, RDATA);
    end
  endtask

  task automatic test_single();
    logic [1:0] resp; logic [3:0] bid; int eb; beat_t e, o;
    wq.push_back(32'hDEADBEEF);
    do_write(4'h3, 32'h40, 8'd0, 3'b010, INCR, 4'hF, -1, resp, bid, eb);
    model_wr(32'h40, 32'hDEADBEEF, 4'hF);
    checks++; if (resp !== OKAY) begin errors++; $display("[TB] FAIL single_bresp: got %b expected 00", resp); end
    checks++; if (bid !== 4'h3) begin errors++; $display("[TB] FAIL single_bid: got %h expected 3", bid); end
    push_exp(32'h40, 0, INCR, 1'b0, 4'h6);
    do_read(4'h6, 32'h40, 8'd0, 3'b010, INCR, -1, 0);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 2", lat); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL single_rbeat: missing, expected %h", e.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("[TB] FAIL single_rbeat: got d=%h r=%b l=%b id=%h expected d=%h r=%b l=%b id=%h", o.data, o.resp, o.last, o.id, e.data, e.resp, e.last, e.id); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL single_extra: got %0d extra beats expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_incr();
    logic [1:0] resp; logic [3:0] bid; int eb; beat_t e, o;
    for (int i = 1; i <= 4; i++) begin
      wq.push_back(32'(i));
      model_wr(32'h100 + 32'(4 * (i - 1)), 32'(i), 4'hF);
    end
    do_write(4'h1, 32'h100, 8'd3, 3'b010, INCR, 4'hF, -1, resp, bid, eb);
    checks++; if (resp !== OKAY || bid !== 4'h1) begin errors++; $display("[TB] FAIL incr_b: got resp=%b id=%h expected 00/1", resp, bid); end
    push_exp(32'h100, 3, INCR, 1'b0, 4'h2);
    stall_q.delete();
    do_read(4'h2, 32'h100, 8'd3, 3'b010, INCR, 1, 3);
    checks++; if (stall_q.size() != 3) begin errors++; $display("[TB] FAIL incr_stall_n: got %0d samples expected 3", stall_q.size()); end
    foreach (stall_q[k]) begin
      checks++;
      if (stall_q[k] !== 32'h2) begin errors++; $display("[TB] FAIL incr_hold: cycle %0d got %h expected 00000002", k, stall_q[k]); end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL incr_rbeat: missing, expected %h", e.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("[TB] FAIL incr_rbeat: got d=%h r=%b l=%b id=%h expected d=%h r=%b l=%b id=%h", o.data, o.resp, o.last, o.id, e.data, e.resp, e.last, e.id); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL incr_extra: got %0d extra beats expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_strobe();
    logic [1:0] resp; logic [3:0] bid; int eb; beat_t e, o;
    logic [31:0] fixed_data [3];
    fixed_data[0] = 32'hAABBCCDD; fixed_data[1] = 32'h55667788; fixed_data[2] = 32'h99AABBEE;
    wq.push_back(32'h11223344);
    do_write(4'h4, 32'h180, 8'd0, 3'b010, INCR, 4'hF, -1, resp, bid, eb);
    model_wr(32'h180, 32'h11223344, 4'hF);
    wq.push_back(32'hAABBCCDD);
    do_write(4'h4, 32'h180, 8'd0, 3'b010, INCR, 4'b0010, -1, resp, bid, eb);
    model_wr(32'h180, 32'hAABBCCDD, 4'b0010);
    checks++; if (resp !== OKAY) begin errors++; $display("[TB] FAIL strobe_bresp: got %b expected 00", resp); end
    push_exp(32'h180, 0, INCR, 1'b0, 4'h4);
    do_read(4'h4, 32'h180, 8'd0, 3'b010, INCR, -1, 0);
    wq.push_back(32'h11223344); wq.push_back(32'hCAFEF00D);
    do_write(4'h5, 32'h200, 8'd1, 3'b010, INCR, 4'hF, -1, resp, bid, eb);
    model_wr(32'h200, 32'h11223344, 4'hF); model_wr(32'h204, 32'hCAFEF00D, 4'hF);
    for (int i = 0; i < 3; i++) begin
      wq.push_back(fixed_data[i]);
      model_wr(32'h200, fixed_data[i], 4'b0010);
    end
    do_write(4'h5, 32'h200, 8'd2, 3'b010, FIXED, 4'b0010, -1, resp, bid, eb);
    checks++; if (resp !== OKAY) begin errors++; $display("[TB] FAIL fixed_bresp: got %b expected 00", resp); end
    push_exp(32'h200, 1, INCR, 1'b0, 4'h7);
    do_read(4'h7, 32'h200, 8'd1, 3'b010, INCR, -1, 0);
    push_exp(32'h204, 1, FIXED, 1'b0, 4'h8);
    do_read(4'h8, 32'h204, 8'd1, 3'b010, FIXED, -1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL strobe_rbeat: missing, expected %h", e.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("[TB] FAIL strobe_rbeat: got d=%h r=%b l=%b id=%h expected d=%h r=%b l=%b id=%h", o.data, o.resp, o.last, o.id, e.data, e.resp, e.last, e.id); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL strobe_extra: got %0d extra beats expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_errors();
    logic [1:0] resp; logic [3:0] bid; int eb; beat_t e, o;
    wq.push_back(32'h01234567);
    do_write(4'h2, 32'h0, 8'd0, 3'b010, INCR, 4'hF, -1, resp, bid, eb);
    model_wr(32'h0, 32'h01234567, 4'hF);
    wq.push_back(32'hFFFFFFFF);
    do_write(4'h9, 32'h0010_0000, 8'd0, 3'b010, INCR, 4'hF, -1, resp, bid, eb);
    checks++; if (resp !== SLVERR || bid !== 4'h9) begin errors++; $display("[TB] FAIL oor_bresp: got resp=%b id=%h expected 10/9", resp, bid); end
    wq.push_back(32'h0);
    do_write(4'h9, 32'h40, 8'd0, 3'b001, INCR, 4'hF, -1, resp, bid, eb);
    checks++; if (resp !== SLVERR) begin errors++; $display("[TB] FAIL size_bresp: got %b expected 10", resp); end
    wq.push_back(32'h0); wq.push_back(32'h0);
    do_write(4'h9, 32'h40, 8'd1, 3'b010, WRAP, 4'hF, -1, resp, bid, eb);
    checks++; if (resp !== SLVERR) begin errors++; $display("[TB] FAIL wrap_bresp: got %b expected 10", resp); end
    push_exp(32'h0, 0, INCR, 1'b0, 4'h1);
    do_read(4'h1, 32'h0, 8'd0, 3'b010, INCR, -1, 0);
    push_exp(32'h40, 0, INCR, 1'b0, 4'h1);
    do_read(4'h1, 32'h40, 8'd0, 3'b010, INCR, -1, 0);
    push_exp(32'h0010_0000, 1, INCR, 1'b1, 4'hC);
    do_read(4'hC, 32'h0010_0000, 8'd1, 3'b010, INCR, -1, 0);
    push_exp(32'h40, 1, WRAP, 1'b1, 4'hD);
    do_read(4'hD, 32'h40, 8'd1, 3'b010, WRAP, -1, 0);
    push_exp(32'h40, 0, INCR, 1'b1, 4'hE);
    do_read(4'hE, 32'h40, 8'd0, 3'b000, INCR, -1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL err_rbeat: missing, expected %h", e.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("[TB] FAIL err_rbeat: got d=%h r=%b l=%b id=%h expected d=%h r=%b l=%b id=%h", o.data, o.resp, o.last, o.id, e.data, e.resp, e.last, e.id); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL err_extra: got %0d extra beats expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_wlast_and_simul();
    logic [1:0] resp, resp2; logic [3:0] bid, bid2; int eb, eb2; beat_t e, o;
    for (int i = 0; i < 4; i++) begin
      wq.push_back(32'hA000_0000 + 32'(i));
      model_wr(32'h280 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
    end
    do_write(4'h6, 32'h280, 8'd3, 3'b010, INCR, 4'hF, 1, resp, bid, eb);
    checks++; if (resp !== SLVERR) begin errors++; $display("[TB] FAIL wlast_bresp: got %b expected 10", resp); end
    checks++; if (eb !== 0) begin errors++; $display("[TB] FAIL wlast_early_b: got %0d early BVALID beats expected 0", eb); end
    push_exp(32'h280, 3, INCR, 1'b0, 4'h3);
    do_read(4'h3, 32'h280, 8'd3, 3'b010, INCR, -1, 0);
    push_exp(32'h40, 0, INCR, 1'b0, 4'h7);
    wq.push_back(32'h12345678);
    fork
      do_write(4'h8, 32'h40, 8'd0, 3'b010, INCR, 4'hF, -1, resp2, bid2, eb2);
      do_read(4'h7, 32'h40, 8'd0, 3'b010, INCR, -1, 0);
    join
    model_wr(32'h40, 32'h12345678, 4'hF);
    checks++; if (resp2 !== OKAY || bid2 !== 4'h8) begin errors++; $display("[TB] FAIL simul_b: got resp=%b id=%h expected 00/8", resp2, bid2); end
    push_exp(32'h40, 0, INCR, 1'b0, 4'h7);
    do_read(4'h7, 32'h40, 8'd0, 3'b010, INCR, -1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL wlast_simul_rbeat: missing, expected %h", e.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("[TB] FAIL wlast_simul_rbeat: got d=%h r=%b l=%b id=%h expected d=%h r=%b l=%b id=%h", o.data, o.resp, o.last, o.id, e.data, e.resp, e.last, e.id); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL wlast_simul_extra: got %0d extra beats expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp; logic [3:0] bid; int eb, t, stale; beat_t e, o;
    @(posedge clk); #1;
    ARID = 4'h5; ARADDR = 32'h100; ARLEN = 8'd7; ARSIZE = 3'b010; ARBURST = INCR;
    ARVALID = 1'b1; RREADY = 1'b1;
    @(posedge clk); #1;
    ARVALID = 1'b0;
    for (int beat = 0; beat < 2; beat++) begin
      t = 0;
      while (!RVALID && t < 20) begin @(posedge clk); #1; t++; end
      checks++; if (t >= 20) begin errors++; $display("[TB] FAIL rstmid_rvalid: beat %0d RVALID got 0 expected 1", beat); end
      if (beat == 0) begin @(posedge clk); #1; end
    end
    sys_rst = 1'b1; RREADY = 1'b0;
    #1;
    checks++;
    if ({ARREADY, RVALID, RLAST} !== 3'b100 || RDATA !== 32'h0 || RRESP !== 2'b00 || RID !== 4'h0) begin
      errors++;
      $display("[TB] FAIL rstmid_read: got ARREADY=%b RVALID=%b RLAST=%b RDATA=%h RRESP=%b RID=%h expected 1/0/0/0/0/0",
               ARREADY, RVALID, RLAST, RDATA, RRESP, RID);
    end
    @(posedge clk); #1;
    sys_rst = 1'b0; RREADY = 1'b1; stale = 0;
    repeat (6) begin @(posedge clk); #1; if (RVALID) stale++; end
    checks++; if (stale != 0) begin errors++; $display("[TB] FAIL rstmid_stale_r: got %0d RVALID cycles expected 0", stale); end
    RREADY = 1'b0;
    AWID = 4'hB; AWADDR = 32'h300; AWLEN = 8'd7; AWSIZE = 3'b010; AWBURST = INCR; AWVALID = 1'b1;
    @(posedge clk); #1;
    AWVALID = 1'b0;
    WDATA = 32'h0000_00A0; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    @(posedge clk); #1;
    WDATA = 32'h0000_00A1;
    @(posedge clk); #1;
    WVALID = 1'b0;
    model_wr(32'h300, 32'h0000_00A0, 4'hF); model_wr(32'h304, 32'h0000_00A1, 4'hF);
    sys_rst = 1'b1;
    #1;
    checks++;
    if ({AWREADY, WREADY, BVALID} !== 3'b100 || BRESP !== 2'b00 || BID !== 4'h0) begin
      errors++;
      $display("[TB] FAIL rstmid_write: got AWREADY=%b WREADY=%b BVALID=%b BRESP=%b BID=%h expected 1/0/0/0/0",
               AWREADY, WREADY, BVALID, BRESP, BID);
    end
    @(posedge clk); #1;
    sys_rst = 1'b0; BREADY = 1'b1; stale = 0;
    repeat (6) begin @(posedge clk); #1; if (BVALID) stale++; end
    checks++; if (stale != 0) begin errors++; $display("[TB] FAIL rstmid_stale_b: got %0d BVALID cycles expected 0", stale); end
    BREADY = 1'b0;
    push_exp(32'h100, 3, INCR, 1'b0, 4'hA);
    do_read(4'hA, 32'h100, 8'd3, 3'b010, INCR, -1, 0);
    push_exp(32'h300, 1, INCR, 1'b0, 4'hA);
    do_read(4'hA, 32'h300, 8'd1, 3'b010, INCR, -1, 0);
    wq.push_back(32'h5A5A5A5A);
    do_write(4'hF, 32'h308, 8'd0, 3'b010, INCR, 4'hF, -1, resp, bid, eb);
    model_wr(32'h308, 32'h5A5A5A5A, 4'hF);
    checks++; if (resp !== OKAY || bid !== 4'hF) begin errors++; $display("[TB] FAIL rstmid_newwrite: got resp=%b id=%h expected 00/f", resp, bid); end
    push_exp(32'h308, 0, INCR, 1'b0, 4'h0);
    do_read(4'h0, 32'h308, 8'd0, 3'b010, INCR, -1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL rstmid_rbeat: missing, expected %h", e.data); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("[TB] FAIL rstmid_rbeat: got d=%h r=%b l=%b id=%h expected d=%h r=%b l=%b id=%h", o.data, o.resp, o.last, o.id, e.data, e.resp, e.last, e.id); end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL rstmid_extra: got %0d extra beats expected 0", obs_q.size()); end
    obs_q.delete();
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sys_rst = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = INCR; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010; ARBURST = INCR; ARVALID = 1'b0;
    RREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sys_rst = 1'b0;
    $display("[TB] starting");
    test_reset();
    test_single();
    test_incr();
    test_strobe();
    test_errors();
    test_wlast_and_simul();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
